// File: rtl/md5_keyspace_engine.sv
// Brute-force MD5 candidate engine: walks the keyspace, builds candidates through a charset RAM,
// farms them out to LANES MD5 cores and streams the first candidate whose digest hits the target.
module md5_keyspace_engine #(
  parameter int LANES   = 1,
  parameter int LEN     = 8,
  parameter int CS_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [127:0]         target,
  output logic [CS_BITS-1:0]   cs_addr,
  input  logic [7:0]           cs_data,
  output logic [LEN*8-1:0]     cand,
  output logic [7:0]           cand_width,
  output logic [LANES-1:0]     cand_valid,
  input  logic [LANES-1:0]     lane_ready,
  input  logic [LANES*128-1:0] lane_hash,
  input  logic [LANES-1:0]     lane_hash_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 found,
  output logic                 done
);

  localparam int W  = LEN * CS_BITS;
  localparam int MW = LEN * 8;
  localparam int CW = $clog2(LEN + 1);
  localparam int SEL_N = 2 ** CW;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DISPATCH,
    DRAIN,
    SEND,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]     idx_reg;
  logic [CW-1:0]    fcnt_reg;
  logic [CW-1:0]    scnt_reg;
  logic [127:0]     target_reg;
  logic [LANES-1:0] pending_reg;
  logic [MW-1:0]    shadow_reg [LANES];
  logic [MW-1:0]    cand_reg;
  logic [MW-1:0]    result_reg;
  logic             found_reg;

  logic             load;
  logic             check_en;
  logic             fetch_last;
  logic             last_idx;
  logic             dispatch_fire;
  logic [LANES-1:0] free;
  logic [LANES-1:0] grant;
  logic [LANES-1:0] hash_ack;
  logic [LANES-1:0] hit;
  logic [LANES-1:0] win;
  logic             any_hit;
  logic [MW-1:0]    win_shadow;
  logic [LEN-1:0]   cap_sel;

  logic [CS_BITS-1:0] digit    [SEL_N];
  logic [7:0]         res_byte [SEL_N];

  // Digit and result-byte views padded to a power of two so the counters index them directly.
  generate
    for (genvar gi = 0; gi < SEL_N; gi++) begin : g_sel
      if (gi < LEN) begin : g_used
        assign digit[gi]    = idx_reg[gi*CS_BITS +: CS_BITS];
        assign res_byte[gi] = result_reg[(LEN-1-gi)*8 +: 8];
      end else begin : g_pad
        assign digit[gi]    = '0;
        assign res_byte[gi] = 8'h00;
      end
    end
  endgenerate

  // cs_data for char i arrives while fcnt_reg == i+1.
  generate
    for (genvar gi = 0; gi < LEN; gi++) begin : g_cap
      assign cap_sel[gi] = (state_reg == FETCH) && (fcnt_reg == CW'(gi + 1));
    end
  endgenerate

  assign check_en = (state_reg == FETCH) || (state_reg == DISPATCH) || (state_reg == DRAIN);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign free[gi]     = lane_ready[gi] & ~pending_reg[gi];
      assign hash_ack[gi] = check_en & lane_hash_valid[gi] & pending_reg[gi];
      assign hit[gi]      = hash_ack[gi] && (lane_hash[gi*128 +: 128] == target_reg);
    end
  endgenerate

  // Lowest set bit wins for both dispatch and match arbitration.
  assign grant   = free & (~free + LANES'(1));
  assign win     = hit & (~hit + LANES'(1));
  assign any_hit = |hit;

  always_comb begin
    win_shadow = '0;
    for (int k = 0; k < LANES; k++) begin
      if (win[k]) begin
        win_shadow = win_shadow | shadow_reg[k];
      end
    end
  end

  assign load          = ((state_reg == IDLE) || (state_reg == DONE)) && start;
  assign fetch_last    = (fcnt_reg == CW'(LEN));
  assign last_idx      = &idx_reg;
  assign dispatch_fire = (state_reg == DISPATCH) && (|free);

  always_comb begin
    state_next = state_reg;
    cand_valid = '0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (fetch_last) state_next = DISPATCH;
      end
      DISPATCH: begin
        if (|free) begin
          cand_valid = grant;
          state_next = last_idx ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (pending_reg == '0) state_next = DONE;
      end
      SEND: begin
        if (tx_ready && (scnt_reg == CW'(LEN - 1))) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    // A hit outranks whatever the walk wanted to do this cycle.
    if (any_hit) state_next = SEND;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      fcnt_reg    <= '0;
      scnt_reg    <= '0;
      target_reg  <= '0;
      pending_reg <= '0;
      result_reg  <= '0;
      found_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= (pending_reg & ~hash_ack) | cand_valid;
      if (state_reg == FETCH) begin
        fcnt_reg <= fetch_last ? '0 : fcnt_reg + CW'(1);
      end
      if (dispatch_fire && !last_idx) begin
        idx_reg <= idx_reg + W'(1);
      end
      if ((state_reg == SEND) && tx_ready) begin
        scnt_reg <= scnt_reg + CW'(1);
      end
      if (any_hit) begin
        result_reg <= win_shadow;
        found_reg  <= 1'b1;
        scnt_reg   <= '0;
      end
      if (load) begin
        target_reg  <= target;
        idx_reg     <= '0;
        fcnt_reg    <= '0;
        pending_reg <= '0;
        found_reg   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_reg <= '0;
    end else begin
      for (int i = 0; i < LEN; i++) begin
        if (cap_sel[i]) cand_reg[(LEN-1-i)*8 +: 8] <= cs_data;
      end
    end
  end

  // Each lane keeps the candidate it is hashing so a late digest can be traced back to its input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LANES; k++) shadow_reg[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (cand_valid[k]) shadow_reg[k] <= cand_reg;
      end
    end
  end

  assign cs_addr    = (state_reg == FETCH) ? digit[fcnt_reg] : '0;
  assign cand       = cand_reg;
  assign cand_width = 8'(MW);
  assign tx_data    = res_byte[scnt_reg];
  assign tx_valid   = (state_reg == SEND);
  assign busy       = (state_reg == FETCH) || (state_reg == DISPATCH) ||
                      (state_reg == DRAIN) || (state_reg == SEND);
  assign found      = found_reg;
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_md5_keyspace_engine.sv
// Scoreboard bench for md5_keyspace_engine: LEN=2, CS_BITS=2, charset "abcd", three model MD5 cores.
module tb_md5_keyspace_engine;

  localparam int LANES   = 3;
  localparam int LEN     = 2;
  localparam int CS_BITS = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [127:0]       target = '0;
  logic [CS_BITS-1:0] cs_addr;
  logic [7:0]         cs_data;
  logic [LEN*8-1:0]   cand;
  logic [7:0]         cand_width;
  logic [LANES-1:0]   cand_valid;
  logic [LANES-1:0]   lane_ready = 3'b001;
  logic [LANES*128-1:0] lane_hash = '0;
  logic [LANES-1:0]   lane_hash_valid = '0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b1;
  logic               busy, found, done;

  md5_keyspace_engine #(.LANES(LANES), .LEN(LEN), .CS_BITS(CS_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .target(target),
    .cs_addr(cs_addr), .cs_data(cs_data), .cand(cand), .cand_width(cand_width),
    .cand_valid(cand_valid), .lane_ready(lane_ready), .lane_hash(lane_hash),
    .lane_hash_valid(lane_hash_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .found(found), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] charset [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
  always @(posedge clk) cs_data <= charset[cs_addr];

  // ---------------- reference MD5 (single block, 2-byte message) ----------------
  function automatic logic [31:0] md5_k(input int i);
    real s;
    s = $sin(real'(i + 1));
    if (s < 0.0) s = -s;
    return 32'(longint'($floor(s * 4294967296.0)));
  endfunction

  function automatic int md5_s(input int i);
    int r;
    r = i % 4;
    case (i / 16)
      0:       return (r == 0) ? 7 : (r == 1) ? 12 : (r == 2) ? 17 : 22;
      1:       return (r == 0) ? 5 : (r == 1) ? 9  : (r == 2) ? 14 : 20;
      2:       return (r == 0) ? 4 : (r == 1) ? 11 : (r == 2) ? 16 : 23;
      default: return (r == 0) ? 6 : (r == 1) ? 10 : (r == 2) ? 15 : 21;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] md5_2(input logic [15:0] msg);
    logic [7:0]  blk [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f;
    int g;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[0] = msg[15:8];
    blk[1] = msg[7:0];
    blk[2] = 8'h80;
    blk[56] = 8'd16;
    for (int j = 0; j < 16; j++) m[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      f = f + a + md5_k(i) + m[g];
      a = d; d = c; c = b;
      b = b + rotl(f, md5_s(i));
    end
    return {bswap(a + 32'h67452301), bswap(b + 32'hefcdab89),
            bswap(c + 32'h98badcfe), bswap(d + 32'h10325476)};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] msg;
    logic [2:0]  lane;
  } disp_t;

  disp_t      exp_disp [$];
  logic [7:0] exp_tx [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_d(input logic [15:0] m, input logic [2:0] l);
    disp_t e;
    e.msg  = m;
    e.lane = l;
    exp_disp.push_back(e);
  endtask

  // ---------------- model MD5 cores ----------------
  int         lat [3] = '{5, 5, 5};
  logic [2:0] ovr = 3'b000;
  int         cnt [3] = '{0, 0, 0};
  logic [15:0] msg_q [3];
  int         match_cyc = -1;
  int         last_ret_cyc = -1;

  always @(negedge clk) begin
    logic [127:0] h;
    for (int k = 0; k < LANES; k++) begin
      lane_hash_valid[k] = 1'b0;
      if (!reset_n) begin
        cnt[k] = 0;
      end else if (cnt[k] > 0) begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin
          h = ovr[k] ? target : md5_2(msg_q[k]);
          lane_hash[k*128 +: 128] = h;
          lane_hash_valid[k] = 1'b1;
          last_ret_cyc = cyc;
          if (h == target) match_cyc = cyc;
        end
      end
      if (reset_n && cand_valid[k]) begin
        cnt[k]   = lat[k];
        msg_q[k] = cand;
      end
    end
  end

  // ---------------- monitor ----------------
  logic       prev_found = 1'b0;
  logic       prev_txv = 1'b0;
  logic       prev_txr = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  int         start_cyc = -1;
  bit         first_disp = 1'b0;

  always @(negedge clk) begin
    disp_t      e;
    logic [7:0] b;
    if (reset_n) begin
      if (cand_valid != '0) begin
        $display("dispatch cyc=%0d lane=%b cand=%s", cyc, cand_valid, cand);
        if (first_disp) begin
          chk("start_to_dispatch", 128'(cyc - start_cyc), 128'(LEN + 2));
          first_disp = 1'b0;
        end
        if (exp_disp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_extra actual=%s lanes=%b required=no dispatch", cand, cand_valid);
        end else begin
          e = exp_disp.pop_front();
          chk("disp_cand", 128'(cand), 128'(e.msg));
          chk("disp_lane", 128'(cand_valid), 128'(e.lane));
        end
      end
      if (prev_txv && !prev_txr) begin
        chk("tx_hold_valid", 128'(tx_valid), 128'(1));
        chk("tx_hold_data", 128'(tx_data), 128'(prev_txd));
      end
      if (tx_valid && tx_ready) begin
        $display("tx cyc=%0d byte=%s", cyc, tx_data);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra actual=%0h required=no byte", tx_data);
        end else begin
          b = exp_tx.pop_front();
          chk("tx_byte", 128'(tx_data), 128'(b));
        end
      end
      if (found && !prev_found) begin
        chk("found_latency", 128'(cyc), 128'(match_cyc + 1));
        chk("found_tx_valid", 128'(tx_valid), 128'(1));
      end
    end
    prev_found = found;
    prev_txv   = tx_valid;
    prev_txr   = tx_ready;
    prev_txd   = tx_data;
  end

  // ---------------- stimulus ----------------
  int done_cyc = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] t);
    target     = t;
    start      = 1'b1;
    start_cyc  = cyc;
    first_disp = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    done_cyc = cyc;
    chk({name, "_done"}, 128'(done), 128'(1));
  endtask

  task automatic check_queues(input string name);
    chk({name, "_disp_left"}, 128'(exp_disp.size()), 128'(0));
    chk({name, "_tx_left"}, 128'(exp_tx.size()), 128'(0));
  endtask

  task automatic check_reset(input string name);
    @(negedge clk);
    chk({name, "_cs_addr"}, 128'(cs_addr), 128'(0));
    chk({name, "_cand"}, 128'(cand), 128'(0));
    chk({name, "_cand_valid"}, 128'(cand_valid), 128'(0));
    chk({name, "_tx_data"}, 128'(tx_data), 128'(0));
    chk({name, "_tx_valid"}, 128'(tx_valid), 128'(0));
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_found"}, 128'(found), 128'(0));
    chk({name, "_done"}, 128'(done), 128'(0));
  endtask

  logic [15:0] s1_seq [7] = '{"aa", "ba", "ca", "da", "ab", "bb", "cb"};

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_reset("rst0");
    chk("cand_width", 128'(cand_width), 128'(16));
    reset_n = 1'b1;
    tick();

    // 1: single usable lane, target md5("cb")
    lane_ready = 3'b001;
    for (int i = 0; i < 7; i++) exp_d(s1_seq[i], 3'b001);
    exp_tx.push_back(8'h63);
    exp_tx.push_back(8'h62);
    pulse_start(md5_2("cb"));
    wait_done("s1", 300);
    chk("s1_found", 128'(found), 128'(1));
    check_queues("s1");
    repeat (12) tick();

    // 2: target outside the keyspace, full walk then drain
    for (int i = 0; i < 16; i++) exp_d({charset[i % 4], charset[i / 4]}, 3'b001);
    pulse_start(128'h0);
    wait_done("s2", 400);
    chk("s2_found", 128'(found), 128'(0));
    chk("s2_drain_to_done", 128'(done_cyc), 128'(last_ret_cyc + 2));
    check_queues("s2");
    repeat (12) tick();

    // 3: lane 1 never ready, lane 2 holds the match, UART stalls 10 cycles
    lane_ready = 3'b101;
    tx_ready   = 1'b0;
    exp_d("aa", 3'b001);
    exp_d("ba", 3'b100);
    exp_d("ca", 3'b001);
    exp_d("da", 3'b100);
    exp_d("ab", 3'b001);
    exp_tx.push_back(8'h64);
    exp_tx.push_back(8'h61);
    pulse_start(md5_2("da"));
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s3_found", 128'(found), 128'(1));
    repeat (10) @(negedge clk);
    chk("s3_stalled_tx_valid", 128'(tx_valid), 128'(1));
    chk("s3_stalled_tx_data", 128'(tx_data), 128'(8'h64));
    tick();
    tx_ready = 1'b1;
    wait_done("s3", 50);
    check_queues("s3");
    repeat (12) tick();

    // 4: lanes 0 and 2 return the target in the same cycle
    lat = '{9, 5, 5};
    ovr = 3'b101;
    exp_d("aa", 3'b001);
    exp_d("ba", 3'b100);
    exp_tx.push_back(8'h61);
    exp_tx.push_back(8'h61);
    pulse_start(128'h0123456789abcdef_fedcba9876543210);
    wait_done("s4", 100);
    chk("s4_found", 128'(found), 128'(1));
    check_queues("s4");
    repeat (12) tick();
    lat = '{5, 5, 5};
    ovr = 3'b000;

    // 6: reset in the middle of FETCH, then a fresh search
    lane_ready = 3'b001;
    pulse_start(md5_2("ba"));
    tick();
    reset_n    = 1'b0;
    first_disp = 1'b0;
    check_reset("rst1");
    tick();
    reset_n = 1'b1;
    tick();
    exp_d("aa", 3'b001);
    exp_d("ba", 3'b001);
    exp_tx.push_back(8'h62);
    exp_tx.push_back(8'h61);
    pulse_start(md5_2("ba"));
    wait_done("s6", 100);
    chk("s6_found", 128'(found), 128'(1));
    check_queues("s6");
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=time %0t required=finish earlier", $time);
    $fatal(1);
  end

endmodule
